// File: rtl/sample_stream_reader_if.sv
// Bus bundle for sample_stream_reader: Avalon-MM read port towards the sample
// memory (s2) plus the valid/ready stream towards the visualizer.
interface sample_stream_reader_if #(
  parameter int ADDR_W = 16
);
  logic [ADDR_W-1:0] m_address;
  logic              m_chipselect;
  logic [3:0]        m_byteenable;
  logic              m_write;
  logic              m_clken;
  logic [31:0]       m_readdata;
  logic [31:0]       src_data;
  logic              src_valid;
  logic              src_ready;
  logic              src_last;

  modport master (
    output m_address, m_chipselect, m_byteenable, m_write, m_clken,
    output src_data, src_valid, src_last,
    input  m_readdata, src_ready
  );

  modport slave (
    input  m_address, m_chipselect, m_byteenable, m_write, m_clken,
    input  src_data, src_valid, src_last,
    output m_readdata, src_ready
  );
endinterface

// File: rtl/sample_stream_reader.sv
// Read master that fetches a run of words from the sample memory and streams
// them out through a show-ahead FIFO, tagging the final word with src_last.
module sample_stream_reader #(
  parameter int ADDR_W       = 16,
  parameter int MEM_WORDS    = 50000,
  parameter int READ_LATENCY = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [ADDR_W-1:0]     word_count,
  output logic                  busy,
  output logic                  done,
  sample_stream_reader_if.master bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] ZERO_A = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ONE_A  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(MEM_WORDS - 1);
  localparam logic [OCC_W-1:0]  ZERO_O = {OCC_W{1'b0}};
  localparam logic [PTR_W-1:0]  ZERO_P = {PTR_W{1'b0}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [ADDR_W-1:0]       remaining_q, remaining_d;
  logic                    cs_q, cs_d, cs_last_q, cs_last_d;
  logic [READ_LATENCY-1:0] tag_vld_q, tag_vld_d, tag_last_q, tag_last_d;
  logic [OCC_W-1:0]        occ_q, occ_d, count_q, count_d;
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [32:0]             fifo_q [FIFO_DEPTH];
  logic [32:0]             fifo_d [FIFO_DEPTH];
  logic                    src_valid_q, src_valid_d;
  logic                    busy_q, busy_d, done_q, done_d;
  logic                    pop_s, push_s, launch_s, free_s, head_last_s;
  logic [ADDR_W-1:0]       rem_src_s;

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      addr_q      <= ZERO_A;
      remaining_q <= ZERO_A;
      cs_q        <= 1'b0;
      cs_last_q   <= 1'b0;
      tag_vld_q   <= {READ_LATENCY{1'b0}};
      tag_last_q  <= {READ_LATENCY{1'b0}};
      occ_q       <= ZERO_O;
      count_q     <= ZERO_O;
      wr_ptr_q    <= ZERO_P;
      rd_ptr_q    <= ZERO_P;
      src_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= 33'd0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      cs_q        <= cs_d;
      cs_last_q   <= cs_last_d;
      tag_vld_q   <= tag_vld_d;
      tag_last_q  <= tag_last_d;
      occ_q       <= occ_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      src_valid_q <= src_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= fifo_d[i];
    end
  end

  assign pop_s       = src_valid_q & bus.src_ready;
  assign push_s      = tag_vld_q[READ_LATENCY-1];
  assign head_last_s = fifo_q[rd_ptr_q][32];

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) state_d = (word_count != ZERO_A) ? FETCH : DONE;
          else       state_d = IDLE;
        end
        FETCH: begin
          if (remaining_q == ZERO_A) state_d = DRAIN;
          else                       state_d = FETCH;
        end
        DRAIN: begin
          if (pop_s && head_last_s) state_d = DONE;
          else                      state_d = DRAIN;
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Status outputs follow the next state so they line up with state_q.
  always_comb begin
    busy_d = (state_d == FETCH) || (state_d == DRAIN);
    done_d = (state_d == DONE);
  end

  // Read issue, address/remaining bookkeeping, inflight tags and FIFO.
  always_comb begin
    launch_s = (state_q == IDLE) && start && (word_count != ZERO_A) && !abort;
    if (launch_s) rem_src_s = word_count;
    else          rem_src_s = remaining_q;
    // occ counts FIFO words plus reads not yet landed, so a slot is reserved per issue.
    free_s    = (occ_q - OCC_W'(pop_s)) < OCC_W'(FIFO_DEPTH);
    cs_d      = (launch_s || (state_q == FETCH && !abort)) && (rem_src_s != ZERO_A) && free_s;
    cs_last_d = cs_d && (rem_src_s == ONE_A);

    if (abort)                   remaining_d = ZERO_A;
    else if (launch_s)           remaining_d = word_count - ADDR_W'(cs_d);
    else if (state_q == FETCH)   remaining_d = remaining_q - ADDR_W'(cs_d);
    else                         remaining_d = remaining_q;

    if (launch_s)  addr_d = base_addr;
    else if (cs_q) addr_d = (addr_q == LAST_A) ? ZERO_A : addr_q + ONE_A;
    else           addr_d = addr_q;

    tag_vld_d     = tag_vld_q;
    tag_last_d    = tag_last_q;
    tag_vld_d[0]  = cs_q & ~abort;
    tag_last_d[0] = cs_last_q;
    for (int i = 1; i < READ_LATENCY; i++) begin
      tag_vld_d[i]  = tag_vld_q[i-1] & ~abort;
      tag_last_d[i] = tag_last_q[i-1];
    end

    fifo_d = fifo_q;
    if (push_s) fifo_d[wr_ptr_q] = {tag_last_q[READ_LATENCY-1], bus.m_readdata};
    else        fifo_d[wr_ptr_q] = fifo_q[wr_ptr_q];

    if (abort) begin
      occ_d    = ZERO_O;
      count_d  = ZERO_O;
      wr_ptr_d = ZERO_P;
      rd_ptr_d = ZERO_P;
    end else begin
      occ_d    = occ_q + OCC_W'(cs_d) - OCC_W'(pop_s);
      count_d  = count_q + OCC_W'(push_s) - OCC_W'(pop_s);
      wr_ptr_d = wr_ptr_q + PTR_W'(push_s);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop_s);
    end
    src_valid_d = (count_d != ZERO_O);
  end

  assign busy             = busy_q;
  assign done             = done_q;
  assign bus.m_address    = addr_q;
  assign bus.m_chipselect = cs_q;
  assign bus.m_byteenable = 4'hF;
  assign bus.m_write      = 1'b0;
  assign bus.m_clken      = 1'b1;
  assign bus.src_valid    = src_valid_q;
  assign bus.src_data     = fifo_q[rd_ptr_q][31:0];
  assign bus.src_last     = fifo_q[rd_ptr_q][32] & src_valid_q;
endmodule

// File: tb/tb_sample_stream_reader.sv
// Scoreboard bench for sample_stream_reader: directed runs push expected words,
// a negedge monitor pops and compares every stream handshake.
module tb_sample_stream_reader;
  localparam int ADDR_W    = 16;
  localparam int MEM_WORDS = 50000;
  localparam int RL        = 1;
  localparam int DEPTH     = 4;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [ADDR_W-1:0] word_count = '0;
  logic              busy, done;
  logic              ready = 1'b1;
  logic [31:0]       rd_q = '0;
  logic [31:0]       mem [MEM_WORDS];

  sample_stream_reader_if #(.ADDR_W(ADDR_W)) bus ();

  sample_stream_reader #(
    .ADDR_W(ADDR_W), .MEM_WORDS(MEM_WORDS), .READ_LATENCY(RL), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .base_addr(base_addr), .word_count(word_count),
    .busy(busy), .done(done), .bus(bus)
  );

  always #5 clk = ~clk;

  // Single-cycle-latency memory model on port s2.
  always @(posedge clk) if (bus.m_chipselect) rd_q <= mem[bus.m_address];
  assign bus.m_readdata = rd_q;
  assign bus.src_ready  = ready;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0, fails = 0;
  logic [32:0] exp_q[$];
  int hs_cyc[$];
  int addr_log[$];
  int done_cnt = 0, done_cyc = -1, valid_cnt = 0, cs_cnt = 0;
  int issued = 0, popped = 0, max_out = 0;
  int t0 = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: scoreboard pop, stall stability, issue log and done timing.
  initial begin
    logic        stall_prev;
    logic [32:0] stall_word, w;
    stall_prev = 1'b0;
    stall_word = '0;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (stall_prev)
          check("stall_hold", {bus.src_valid, bus.src_last, bus.src_data}, {1'b1, stall_word});
        stall_prev = bus.src_valid & ~bus.src_ready;
        stall_word = {bus.src_last, bus.src_data};
        if (bus.src_valid) valid_cnt++;
        if (bus.m_chipselect) begin
          cs_cnt++;
          issued++;
          addr_log.push_back(int'(bus.m_address));
        end
        if (bus.src_valid && bus.src_ready) begin
          popped++;
          hs_cyc.push_back(cyc);
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_word: got 0x%0h, expected no word", {bus.src_last, bus.src_data});
          end else begin
            w = exp_q.pop_front();
            check("stream_word", {bus.src_last, bus.src_data}, w);
          end
        end
        if (issued - popped > max_out) max_out = issued - popped;
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
          check("busy_low_at_done", busy, 1'b0);
        end
      end else begin
        stall_prev = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input int base, input int cnt);
    logic [32:0] w;
    for (int i = 0; i < cnt; i++) begin
      w = {(i == cnt - 1), mem[(base + i) % MEM_WORDS]};
      exp_q.push_back(w);
    end
    hs_cyc.delete();
    addr_log.delete();
    done_cnt = 0; done_cyc = -1; valid_cnt = 0; cs_cnt = 0;
    issued = 0; popped = 0; max_out = 0;
    base_addr = ADDR_W'(base);
    word_count = ADDR_W'(cnt);
    start = 1'b1;
    t0 = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      tick();
      n++;
    end
    check(name, done_cnt != 0, 1'b1);
    tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_cs"}, bus.m_chipselect, 1'b0);
    check({tag, "_valid"}, bus.src_valid, 1'b0);
    check({tag, "_last"}, bus.src_last, 1'b0);
    check({tag, "_addr"}, bus.m_address, 16'h0000);
    check({tag, "_data"}, bus.src_data, 32'h0000_0000);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int wrap_addrs [4] = '{49998, 49999, 0, 1};
    logic [3:0] pat = 4'b1001;
    int n, vc;
    bit aborted;

    for (int i = 0; i < MEM_WORDS; i++) mem[i] = i;

    // Reset state and constant bus outputs.
    #12;
    check_reset_outputs("reset");
    check("byteenable", bus.m_byteenable, 4'hF);
    check("write", bus.m_write, 1'b0);
    check("clken", bus.m_clken, 1'b1);
    tick();
    reset_n = 1'b1;
    tick();

    // Basic run: 8 words from 0x10, cycle-exact timing.
    ready = 1'b1;
    launch(16'h0010, 8);
    check("basic_busy_c1", busy, 1'b1);
    check("basic_cs_c1", bus.m_chipselect, 1'b1);
    check("basic_addr_c1", bus.m_address, 16'h0010);
    wait_done("basic_done_seen", 40);
    check("basic_hs_count", hs_cyc.size(), 8);
    for (int i = 0; i < 8; i++)
      check("basic_hs_cycle", (i < hs_cyc.size()) ? hs_cyc[i] - t0 : -1, 3 + i);
    check("basic_done_cycle", done_cyc - t0, 11);
    check("basic_done_count", done_cnt, 1);
    check("basic_sb_empty", exp_q.size(), 0);

    // Address wrap at MEM_WORDS.
    launch(49998, 4);
    wait_done("wrap_done_seen", 40);
    check("wrap_issue_count", addr_log.size(), 4);
    for (int i = 0; i < 4; i++)
      check("wrap_addr", (i < addr_log.size()) ? addr_log[i] : -1, wrap_addrs[i]);
    check("wrap_sb_empty", exp_q.size(), 0);

    // Backpressure with ready 1-0-0-1.
    launch(100, 16);
    n = 0;
    while (done_cnt == 0 && n < 300) begin
      ready = pat[n % 4];
      tick();
      n++;
    end
    check("bp_done_seen", done_cnt != 0, 1'b1);
    ready = 1'b1;
    tick();
    check("bp_word_count", popped, 16);
    check("bp_sb_empty", exp_q.size(), 0);
    check("bp_max_outstanding_ok", max_out <= DEPTH, 1'b1);

    // Zero-count run.
    launch(5, 0);
    check("zero_busy_c1", busy, 1'b0);
    check("zero_done_c1", done, 1'b1);
    repeat (5) tick();
    check("zero_done_cycle", done_cyc - t0, 1);
    check("zero_done_count", done_cnt, 1);
    check("zero_no_cs", cs_cnt, 0);
    check("zero_no_valid", valid_cnt, 0);

    // Abort on the 3rd handshake of a 10-word run.
    launch(200, 10);
    n = 0;
    aborted = 1'b0;
    while (!aborted && n < 40) begin
      if (bus.src_valid && ready && popped == 2) begin
        abort = 1'b1;
        aborted = 1'b1;
      end
      tick();
      n++;
    end
    abort = 1'b0;
    check("abort_reached", aborted, 1'b1);
    check("abort_busy", busy, 1'b0);
    check("abort_valid", bus.src_valid, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_hs_count", popped, 3);
    exp_q.delete();
    vc = valid_cnt;
    repeat (6) tick();
    check("abort_no_late_valid", valid_cnt, vc);
    check("abort_no_done", done_cnt, 0);
    launch(300, 2);
    wait_done("post_abort_done_seen", 40);
    check("post_abort_words", popped, 2);
    check("post_abort_first", (hs_cyc.size() > 0) ? hs_cyc[0] - t0 : -1, 3);
    check("post_abort_sb_empty", exp_q.size(), 0);

    // Redundant start while busy.
    launch(400, 6);
    base_addr = 16'd500;
    word_count = 16'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("redundant_done_seen", 40);
    check("redundant_words", popped, 6);
    check("redundant_done_count", done_cnt, 1);
    check("redundant_issues", addr_log.size(), 6);
    check("redundant_last_addr", (addr_log.size() == 6) ? addr_log[5] : -1, 405);
    check("redundant_sb_empty", exp_q.size(), 0);

    // Asynchronous reset in the middle of FETCH.
    ready = 1'b0;
    launch(600, 16);
    tick();
    tick();
    check("prereset_busy", busy, 1'b1);
    check("prereset_data", bus.src_data, 32'd600);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    tick();
    tick();
    reset_n = 1'b1;
    exp_q.delete();
    ready = 1'b1;
    tick();
    launch(700, 3);
    wait_done("post_reset_done_seen", 40);
    check("post_reset_words", popped, 3);
    check("post_reset_sb_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sample_stream_reader.md
# sample_stream_reader

Avalon-MM read master that drives the second (s2) port of the dual-port on-chip sample memory. It fetches a programmed run of 32-bit words and presents them as a valid/ready stream with last-word marking. The Nios writes sample buffers through port s1; this block drains them towards the visualizer pipeline without CPU involvement.

## Interface
Parameters:
- `ADDR_W`, 16: word-address width of the memory port.
- `MEM_WORDS`, 50000: memory depth in words; the address wraps at this value.
- `READ_LATENCY`, 1: fixed memory read latency in cycles, from address to `m_readdata`. Range 1–3.
- `FIFO_DEPTH`, 4: output FIFO depth in words, a power of two, at least 2.

Ports:
- `clk`  in  1  sole clock; the memory's `clk2` is on this clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse that launches a run. Sampled only in IDLE.
- `abort`  in  1  cancels the run and flushes the FIFO.
- `base_addr`  in  ADDR_W  first word address, sampled with `start`.
- `word_count`  in  ADDR_W  number of words to fetch, sampled with `start`.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`.
- `done`  out  1  one-cycle completion pulse.
- `m_address`  out  ADDR_W  memory word address.
- `m_chipselect`  out  1  read strobe; one word is requested per cycle in which it is high.
- `m_byteenable`  out  4  constant 4'hF.
- `m_write`  out  1  constant 0.
- `m_clken`  out  1  constant 1.
- `m_readdata`  in  32  memory read data.
- `src_data`  out  32  stream data.
- `src_valid`  out  1  stream valid.
- `src_ready`  in  1  sink ready.
- `src_last`  out  1  marks the final word of the run; qualified by `src_valid`.

## Operation
- States: IDLE, FETCH, DRAIN, DONE.
- **IDLE**
  - `start` with `word_count` ≠ 0: latch the address and count, go to FETCH.
  - `start` with `word_count` = 0: go to DONE. No memory access.
- **FETCH**
  - Issue rule: `m_chipselect` = 1 when `remaining` > 0 and fifo_count + inflight < FIFO_DEPTH.
  - On each issue, `m_address` increments. When it reaches MEM_WORDS−1, the next issued address is 0.
  - `remaining` decrements on each issue. When the last read is issued, go to DRAIN.
- **Inflight tracking**
  - Issued reads are tracked in a READ_LATENCY-deep valid shift register.
  - `m_readdata` is written into the FIFO in the cycle its tag emerges.
  - A word-remaining counter tags the last word; its `src_last` is stored in the FIFO alongside the data.
- **DRAIN**
  - When the handshake `src_valid & src_ready` occurs with `src_last` = 1, go to DONE.
- **DONE**
  - `done` = 1 for one cycle, `busy` = 0, then return to IDLE.
- **FIFO**
  - Show-ahead: `src_data` and `src_last` are valid whenever `src_valid` = 1.
  - A push and a pop in the same cycle are both performed.
  - `src_valid`, `src_data` and `src_last` are held stable while `src_ready` = 0.
- **abort** (any state)
  - Next cycle: state = IDLE, FIFO empty, `src_valid` = 0, `busy` = 0, `done` = 0.
  - Data still in flight when `abort` arrives is discarded. This includes `m_readdata` returning up to READ_LATENCY cycles later.
  - `abort` takes priority over a simultaneous `start`; that `start` is ignored.
- `start` received while `busy` = 1 is ignored.

## Timing
- Reset values:
  - `busy`, `done`, `m_chipselect`, `src_valid`, `src_last` = 0.
  - `m_address`, `src_data` = 0.
  - State = IDLE, FIFO empty.
- With `start` at cycle 0:
  - `busy` = 1 and first `m_chipselect` at cycle 1.
  - `m_readdata` arrives at cycle 1+READ_LATENCY.
  - First `src_valid` at cycle 2+READ_LATENCY.
- Sustained throughput is 1 word/cycle when `src_ready` is held high and FIFO_DEPTH ≥ READ_LATENCY+2.
- `done` asserts the cycle after the final handshake. `busy` falls in that same cycle.
- Zero-count run: `start` at cycle 0 gives `busy` = 0 and `done` = 1 at cycle 1.
- FIFO overflow is impossible by construction. The bench asserts this.

## Test plan
- **Basic run:** `base_addr` = 0x0010, `word_count` = 8, memory[i] = i, `src_ready` = 1.
  - 8 words 0x10..0x17 on consecutive cycles starting at cycle 3.
  - `src_last` only on 0x17.
  - `done` at cycle 11.
- **Wrap:** `base_addr` = 49998, `word_count` = 4.
  - Addresses issued: 49998, 49999, 0, 1.
  - Stream order matches memory contents at those addresses.
- **Backpressure:** `src_ready` toggled 1-0-0-1 repeatedly, 16-word run.
  - No data loss, duplication or reordering; `src_data` stable while stalled.
  - Never more than FIFO_DEPTH words buffered plus in flight.
- **Zero count:** `word_count` = 0.
  - No `m_chipselect` at any time.
  - `done` one cycle after `start`, `src_valid` never asserted.
- **Abort:** `abort` at the 3rd handshake of a 10-word run.
  - Next cycle: FIFO empty, `busy` = 0, no `done`.
  - Late `m_readdata` ignored.
  - A following 2-word run streams correctly.
- **Reset and redundant start:**
  - `reset_n` low mid-FETCH: all outputs return to their reset values immediately, with no clock edge required.
  - `start` pulsed while `busy` = 1: the run is unaffected.
